// File: rtl/fm_step2.sv
// fm_step2 - second stage of the half-precision floating multiplier.
//
// Takes one registered stage-1 bundle, adds the remaining partial-product
// rows one per cycle, normalises the 22-bit significand product and hands
// an exact single-precision-format product downstream.
//
// Ports:
//   CLK          in   rising-edge clock
//   RESET        in   synchronous active-high reset
//   in_valid     in   stage-1 bundle valid
//   in_ready     out  high only while idle (bundle can be accepted)
//   ex_add       in   [7:0]  exponent sum, bias 127
//   out_sign     in   product sign
//   temp_s_r1    in   [21:0] row0 + row1 sum
//   temp_p_r1_2 .. temp_p_r1_10  in [21:0] partial-product rows 2..10
//   prod_valid   out  product valid (registered)
//   prod_ready   in   downstream accepts product
//   prod         out  [31:0] {sign, exp[7:0], frac[22:0]}
//   busy         out  high whenever the block is not idle
module fm_step2 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  ex_add,
  input  logic        out_sign,
  input  logic [21:0] temp_s_r1,
  input  logic [21:0] temp_p_r1_2,
  input  logic [21:0] temp_p_r1_3,
  input  logic [21:0] temp_p_r1_4,
  input  logic [21:0] temp_p_r1_5,
  input  logic [21:0] temp_p_r1_6,
  input  logic [21:0] temp_p_r1_7,
  input  logic [21:0] temp_p_r1_8,
  input  logic [21:0] temp_p_r1_9,
  input  logic [21:0] temp_p_r1_10,
  output logic        prod_valid,
  input  logic        prod_ready,
  output logic [31:0] prod,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [21:0] r_rows [0:8];
  logic [21:0] r_sum;
  logic [3:0]  r_cnt;
  logic        r_sign;
  logic [7:0]  r_exAdd;
  logic [31:0] r_prod;
  logic        r_prodValid;

  logic [21:0] w_row;
  logic [7:0]  w_normExp;
  logic [22:0] w_normFrac;
  logic [31:0] w_prodNorm;

  // State register; reset drops any in-flight operation back to idle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode. ACC runs nine cycles (rows 2..10, cnt 0..8) and
  // DONE waits for the downstream handshake for as long as it takes.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_stateNext = ACC;
      ACC:     if (r_cnt == 4'd8) w_stateNext = NORM;
      NORM:    w_stateNext = DONE;
      DONE:    if (prod_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Row currently being accumulated: entry 0 holds row 2.
  always_comb begin
    w_row = '0;
    if (r_cnt <= 4'd8) begin
      w_row = r_rows[r_cnt];
    end
  end

  // The product of two significands with hidden bit set lies in [1,4), so
  // the leading one sits at bit 21 or bit 20. Dropping that hidden bit and
  // left-aligning the rest into 23 bits keeps every product bit.
  always_comb begin
    w_normExp  = r_exAdd;
    w_normFrac = {r_sum[19:0], 3'b000};
    if (r_sum[21]) begin
      w_normExp  = r_exAdd + 8'd1;
      w_normFrac = {r_sum[20:0], 2'b00};
    end
  end

  assign w_prodNorm = {r_sign, w_normExp, w_normFrac};

  // Datapath: latch the bundle on accept, accumulate one row per cycle,
  // load the normalised product, then hold it until the handshake.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 9; i++) begin
        r_rows[i] <= '0;
      end
      r_sum       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_exAdd     <= '0;
      r_prod      <= '0;
      r_prodValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign    <= out_sign;
            r_exAdd   <= ex_add;
            r_sum     <= temp_s_r1;
            r_cnt     <= '0;
            r_rows[0] <= temp_p_r1_2;
            r_rows[1] <= temp_p_r1_3;
            r_rows[2] <= temp_p_r1_4;
            r_rows[3] <= temp_p_r1_5;
            r_rows[4] <= temp_p_r1_6;
            r_rows[5] <= temp_p_r1_7;
            r_rows[6] <= temp_p_r1_8;
            r_rows[7] <= temp_p_r1_9;
            r_rows[8] <= temp_p_r1_10;
          end
        end
        ACC: begin
          r_sum <= r_sum + w_row;
          r_cnt <= r_cnt + 4'd1;
        end
        NORM: begin
          r_prod      <= w_prodNorm;
          r_prodValid <= 1'b1;
        end
        DONE: begin
          if (prod_ready) begin
            r_prodValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign prod       = r_prod;
  assign prod_valid = r_prodValid;

endmodule
